// File: rtl/enc8b10b_tx_sched.sv
// 8b10b transmit symbol scheduler: link training, packet framing, idle fill,
// clock-compensation skip insertion and running-disparity feedback to the encoder.
module enc8b10b_tx_sched #(
  parameter int TRAIN_PAIRS = 64,
  parameter int CC_INTERVAL = 1024,
  parameter int CC_PAIRS    = 2,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link_en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_sop,
  input  logic       in_eop,
  output logic [7:0] enc_dat,
  output logic       enc_k,
  output logic       enc_ena,
  output logic       enc_rd,
  input  logic       enc_rdcomb,
  output logic       trained,
  output logic       cc_active,
  output logic       abort_pulse
);
  localparam logic [7:0] SYM_K28_5 = 8'hBC;
  localparam logic [7:0] SYM_D16_2 = 8'h50;
  localparam logic [7:0] SYM_K28_0 = 8'h1C;
  localparam logic [7:0] SYM_SOF   = 8'hFB;
  localparam logic [7:0] SYM_EOF   = 8'hFD;
  localparam logic [7:0] SYM_PAD   = 8'hF7;
  localparam logic [7:0] SYM_ABORT = 8'hFE;

  localparam logic [CNT_W-1:0] CC_RELOAD  = CNT_W'(CC_INTERVAL);
  localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_PAIRS - 1);
  localparam logic [CNT_W-1:0] CC_LAST    = CNT_W'(CC_PAIRS - 1);

  typedef enum logic [2:0] {
    S_OFF, S_TRAIN, S_IDLE, S_DATA, S_EOF, S_PAD, S_CC
  } state_t;

  state_t           state_reg;
  logic             odd_reg;       // parity of the slot about to be issued
  logic [CNT_W-1:0] pair_cnt_reg;
  logic [CNT_W-1:0] cc_cnt_reg;
  logic             rd_reg;
  logic             issue_now;
  logic             start_cc;

  // Outside DATA, a dropped link_en only takes effect on an even slot so pairs never split.
  assign issue_now = (state_reg == S_DATA) ||
                     ((state_reg != S_OFF) && (link_en || odd_reg));
  assign start_cc  = (state_reg == S_IDLE) && link_en && !odd_reg && (cc_cnt_reg == '0);
  assign in_ready  = ((state_reg == S_DATA) && link_en) ||
                     ((state_reg == S_IDLE) && in_valid && !in_sop);
  assign enc_rd    = rd_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_OFF;
      odd_reg      <= 1'b0;
      pair_cnt_reg <= '0;
      cc_cnt_reg   <= CC_RELOAD;
      rd_reg       <= 1'b0;
      enc_dat      <= 8'h00;
      enc_k        <= 1'b0;
      enc_ena      <= 1'b0;
      trained      <= 1'b0;
      cc_active    <= 1'b0;
      abort_pulse  <= 1'b0;
    end else begin
      enc_k       <= 1'b0;
      enc_ena     <= 1'b0;
      enc_dat     <= 8'h00;
      cc_active   <= 1'b0;
      abort_pulse <= 1'b0;

      if (enc_k || enc_ena)
        rd_reg <= enc_rdcomb;
      if (issue_now)
        odd_reg <= ~odd_reg;

      if (start_cc)
        cc_cnt_reg <= CC_RELOAD;
      else if (issue_now && (state_reg != S_TRAIN) && (cc_cnt_reg != '0))
        cc_cnt_reg <= cc_cnt_reg - 1'b1;

      case (state_reg)
        S_OFF: begin
          trained    <= 1'b0;
          cc_cnt_reg <= CC_RELOAD;
          odd_reg    <= 1'b0;
          if (link_en) begin
            state_reg    <= S_TRAIN;
            pair_cnt_reg <= '0;
          end
        end
        S_DATA: begin
          if (!link_en) begin
            enc_k       <= 1'b1;
            enc_dat     <= SYM_ABORT;
            abort_pulse <= 1'b1;
            state_reg   <= S_OFF;
          end else if (in_valid) begin
            enc_ena <= 1'b1;
            enc_dat <= in_data;
            if (in_eop)
              state_reg <= S_EOF;
          end else begin
            enc_k   <= 1'b1;
            enc_dat <= SYM_PAD;
          end
        end
        default: begin
          if (!issue_now) begin
            trained   <= 1'b0;
            state_reg <= S_OFF;
          end else begin
            case (state_reg)
              S_TRAIN: begin
                if (!odd_reg) begin
                  enc_k   <= 1'b1;
                  enc_dat <= SYM_K28_5;
                end else begin
                  enc_ena <= 1'b1;
                  enc_dat <= SYM_D16_2;
                  if (pair_cnt_reg == TRAIN_LAST) begin
                    trained   <= 1'b1;
                    state_reg <= S_IDLE;
                  end else begin
                    pair_cnt_reg <= pair_cnt_reg + 1'b1;
                  end
                end
              end
              S_IDLE: begin
                if (odd_reg) begin
                  enc_ena <= 1'b1;
                  enc_dat <= SYM_D16_2;
                end else if (start_cc) begin
                  enc_k        <= 1'b1;
                  enc_dat      <= SYM_K28_5;
                  cc_active    <= 1'b1;
                  pair_cnt_reg <= '0;
                  state_reg    <= S_CC;
                end else if (in_valid && in_sop) begin
                  enc_k     <= 1'b1;
                  enc_dat   <= SYM_SOF;
                  state_reg <= S_DATA;
                end else begin
                  enc_k   <= 1'b1;
                  enc_dat <= SYM_K28_5;
                end
              end
              S_CC: begin
                enc_k     <= 1'b1;
                cc_active <= 1'b1;
                if (!odd_reg) begin
                  enc_dat <= SYM_K28_5;
                end else begin
                  enc_dat <= SYM_K28_0;
                  if (pair_cnt_reg == CC_LAST)
                    state_reg <= S_IDLE;
                  else
                    pair_cnt_reg <= pair_cnt_reg + 1'b1;
                end
              end
              S_EOF: begin
                enc_k     <= 1'b1;
                enc_dat   <= SYM_EOF;
                // An EOF on an even slot leaves an odd slot that must be padded.
                state_reg <= odd_reg ? S_IDLE : S_PAD;
              end
              S_PAD: begin
                enc_k     <= 1'b1;
                enc_dat   <= SYM_PAD;
                state_reg <= S_IDLE;
              end
              default: state_reg <= S_OFF;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_enc8b10b_tx_sched.sv
// Randomized bench for enc8b10b_tx_sched: a queue-based link model predicts every
// symbol, status flag and accept; an encoder disparity model closes the RD loop.
module tb_enc8b10b_tx_sched;
  localparam int TP  = 64;
  localparam int CCI = 16;
  localparam int CCP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       link_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_eop;
  logic [7:0] enc_dat;
  logic       enc_k;
  logic       enc_ena;
  logic       enc_rd;
  logic       enc_rdcomb;
  logic       trained;
  logic       cc_active;
  logic       abort_pulse;
  logic       rd_noise;

  enc8b10b_tx_sched #(
    .TRAIN_PAIRS(TP), .CC_INTERVAL(CCI), .CC_PAIRS(CCP), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .link_en(link_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .enc_dat(enc_dat), .enc_k(enc_k), .enc_ena(enc_ena), .enc_rd(enc_rd),
    .enc_rdcomb(enc_rdcomb), .trained(trained), .cc_active(cc_active),
    .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  // Running-disparity behaviour of a real 8b10b encoder: each unbalanced sub-block flips RD.
  function automatic logic rd_next(input logic rd, input logic [7:0] b, input logic k);
    logic [4:0] x;
    logic [2:0] y;
    logic nn6, nn4;
    x = b[4:0];
    y = b[7:5];
    case (x)
      5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd15, 5'd16, 5'd23,
      5'd24, 5'd27, 5'd29, 5'd30, 5'd31: nn6 = 1'b1;
      default: nn6 = 1'b0;
    endcase
    if (k && x == 5'd28) nn6 = 1'b1;
    nn4 = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
    return rd ^ nn6 ^ nn4;
  endfunction

  assign enc_rdcomb = (enc_k || enc_ena) ? rd_next(enc_rd, enc_dat, enc_k) : rd_noise;

  logic [13:0] dut_vec;
  assign dut_vec = {enc_k, enc_ena, enc_dat, enc_rd, trained, cc_active, abort_pulse};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Upstream packet source.
  typedef struct {logic [7:0] d; bit sop; bit eop; int gap;} byte_t;
  byte_t src[$];
  int pkt_id = 0;

  task automatic push_byte(input logic [7:0] d, input bit sop, input bit eop, input int gap);
    byte_t b;
    b.d = d; b.sop = sop; b.eop = eop; b.gap = gap;
    src.push_back(b);
  endtask

  task automatic push_rand_pkt(input int len, input int gap_max);
    for (int i = 0; i < len; i++)
      push_byte(8'($urandom), i == 0, i == len - 1, $urandom_range(0, 3) == 0 ? $urandom_range(0, gap_max) : 0);
    pkt_id++;
    $display("PKT %0d queued len=%0d", pkt_id, len);
  endtask

  task automatic flush_src();
    while (src.size() != 0 && !src[0].sop) void'(src.pop_front());
  endtask

  // Link model: symbols already committed to (second halves, EOF/pad, skip burst) wait in mq.
  typedef struct {logic [7:0] d; bit k; bit cc;} sym_t;
  sym_t mq[$];
  bit   m_on, m_train, m_pkt, m_par, m_trained;
  int   m_tcnt, m_cc;
  logic m_rd;
  logic       e_k, e_ena, e_rd, e_tr, e_cc, e_ab;
  logic [7:0] e_dat;

  task automatic model_reset();
    mq.delete();
    m_on = 0; m_train = 0; m_pkt = 0; m_par = 0; m_trained = 0;
    m_tcnt = 0; m_cc = CCI; m_rd = 1'b0;
    e_k = 0; e_ena = 0; e_rd = 0; e_tr = 0; e_cc = 0; e_ab = 0; e_dat = 8'h00;
  endtask

  function automatic sym_t mk(input logic [7:0] d, input bit k, input bit cc);
    sym_t s;
    s.d = d; s.k = k; s.cc = cc;
    return s;
  endfunction

  task automatic model_step(output bit acc);
    bit iss, burst, ab, was_train;
    sym_t s;
    acc = 0; iss = 0; burst = 0; ab = 0;
    s = mk(8'h00, 1'b0, 1'b0);
    if (e_k || e_ena) m_rd = rd_next(m_rd, e_dat, e_k);
    was_train = m_train;
    if (!m_on) begin
      m_par = 0; m_cc = CCI; m_trained = 0;
      if (link_en) begin m_on = 1; m_train = 1; m_tcnt = 0; end
    end else if (m_pkt) begin
      iss = 1;
      if (!link_en) begin
        s = mk(8'hFE, 1, 0); ab = 1; m_on = 0; m_pkt = 0;
      end else if (in_valid) begin
        s = mk(in_data, 0, 0); acc = 1;
        if (in_eop) begin m_pkt = 0; mq.push_back(mk(8'hFD, 1, 0)); end
      end else begin
        s = mk(8'hF7, 1, 0);
      end
    end else if (!link_en && !m_par) begin
      m_on = 0; m_train = 0; m_trained = 0; m_cc = CCI; mq.delete();
    end else begin
      iss = 1;
      if (mq.size() != 0) begin
        s = mq.pop_front();
        if (s.d == 8'hFD && s.k && !m_par) mq.push_back(mk(8'hF7, 1, 0));
      end else if (m_train) begin
        s = mk(8'hBC, 1, 0); mq.push_back(mk(8'h50, 0, 0));
      end else if (m_cc == 0) begin
        burst = 1;
        s = mk(8'hBC, 1, 1);
        mq.push_back(mk(8'h1C, 1, 1));
        for (int i = 1; i < CCP; i++) begin
          mq.push_back(mk(8'hBC, 1, 1));
          mq.push_back(mk(8'h1C, 1, 1));
        end
      end else if (in_valid && in_sop) begin
        s = mk(8'hFB, 1, 0); m_pkt = 1;
      end else begin
        s = mk(8'hBC, 1, 0); mq.push_back(mk(8'h50, 0, 0));
      end
    end
    if (iss) begin
      m_par = ~m_par;
      if (burst) m_cc = CCI;
      else if (!was_train && m_cc > 0) m_cc--;
      if (m_train) begin
        m_tcnt++;
        if (m_tcnt == 2 * TP) begin m_train = 0; m_trained = 1; end
      end
    end
    e_k   = iss && s.k;
    e_ena = iss && !s.k;
    e_dat = iss ? s.d : 8'h00;
    e_cc  = iss && s.cc;
    e_ab  = ab;
    e_tr  = m_trained;
    e_rd  = m_rd;
  endtask

  task automatic drive_src();
    if (src.size() == 0 || src[0].gap > 0) begin
      if (src.size() != 0) src[0].gap = src[0].gap - 1;
      in_valid = 0;
      in_data  = 8'($urandom);
      in_sop   = 1'($urandom);
      in_eop   = 1'($urandom);
    end else begin
      in_valid = 1;
      in_data  = src[0].d;
      in_sop   = src[0].sop;
      in_eop   = src[0].eop;
    end
  endtask

  // One clock: check what the last edge produced, drive the next inputs, predict.
  task automatic cycle();
    bit acc;
    check_eq("sym", dut_vec, {e_k, e_ena, e_dat, e_rd, e_tr, e_cc, e_ab});
    drive_src();
    rd_noise = 1'($urandom);
    #1;
    model_step(acc);
    check_eq("accept", in_ready && in_valid, acc);
    if (acc) void'(src.pop_front());
    if (e_ab) flush_src();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && (src.size() != 0 || m_pkt || mq.size() != 0); i++) cycle();
    check_eq(tag, src.size() + int'(m_pkt), 0);
  endtask

  task automatic wait_in_pkt(input string tag, input int left);
    int i;
    for (i = 0; i < 600 && !(m_pkt && src.size() <= left); i++) cycle();
    check_eq(tag, i < 600, 1);
  endtask

  task automatic async_reset();
    #2 rst = 1;
    #1 check_eq("rst_async", dut_vec, 14'h0);
    @(negedge clk);
    rst = 0;
    model_reset();
    flush_src();
  endtask

  int off_left;

  initial begin
    rst = 1; link_en = 0; in_valid = 0; in_data = 0; in_sop = 0; in_eop = 0; rd_noise = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_out", dut_vec, 14'h0);
    check_eq("rst_ready", in_ready, 0);
    rst = 0;

    // Training then idles with periodic skips.
    link_en = 1;
    run(220);

    // Short packet 11,22,33.
    push_byte(8'h11, 1, 0, 0); push_byte(8'h22, 0, 0, 0); push_byte(8'h33, 0, 1, 0);
    pkt_id++; $display("PKT %0d queued len=3", pkt_id);
    drain("drain_short", 300);
    run(12);

    // Upstream gap of two cycles after the first byte.
    push_byte(8'hA1, 1, 0, 0); push_byte(8'hA2, 0, 0, 2);
    push_byte(8'hA3, 0, 0, 0); push_byte(8'hA4, 0, 1, 0);
    pkt_id++; $display("PKT %0d queued len=4 gap=2", pkt_id);
    drain("drain_gap", 300);
    run(8);

    // Long packet forces a deferred skip burst after EOF.
    push_rand_pkt(40, 0);
    drain("drain_long", 300);
    run(20);

    // Random packets with random gaps and occasional link drops.
    for (int p = 0; p < 25; p++) push_rand_pkt($urandom_range(1, 12), 3);
    off_left = 0;
    for (int i = 0; i < 8000 && src.size() != 0; i++) begin
      if (link_en && $urandom_range(0, 299) == 0) begin
        link_en = 0; off_left = $urandom_range(1, 4);
      end else if (!link_en) begin
        if (off_left == 0) link_en = 1; else off_left--;
      end
      cycle();
    end
    link_en = 1;
    check_eq("drain_rand", src.size(), 0);
    run(10);

    // Link drop mid-packet: abort, OFF, then full retraining.
    push_rand_pkt(20, 0);
    wait_in_pkt("wait_abort", 16);
    link_en = 0;
    run(4);
    link_en = 1;
    run(2 * TP + 20);
    drain("drain_after_abort", 300);

    // Asynchronous reset in the middle of a packet.
    push_rand_pkt(10, 1);
    wait_in_pkt("wait_rst", 7);
    async_reset();
    run(2 * TP + 20);
    push_rand_pkt(6, 2);
    drain("drain_after_rst", 300);
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/enc8b10b_tx_sched.md
Name: enc8b10b_tx_sched

Overview:
Transmit symbol scheduler that sequences the 8b10b encoder on a serial link. It trains the link with idle ordered sets, frames packets from an upstream byte stream, and fills the gaps with idles. It inserts periodic clock-compensation (skip) sets at packet boundaries and owns the running-disparity register fed back around the encoder. It sits between the packet source and the encoder's data, K and running-disparity pins.

Parameters:
TRAIN_PAIRS, 64, number of idle pairs (K28.5,D16.2) sent in TRAIN before data is accepted.
CC_INTERVAL, 1024, symbols between clock-compensation requests (counter reload value).
CC_PAIRS, 2, skip pairs (K28.5,K28.0) per compensation burst.
CNT_W, 16, width of internal symbol/pair counters; CC_INTERVAL and TRAIN_PAIRS must be < 2^CNT_W.

Ports:
clk  in  1  symbol clock, shared with encoder.
rst  in  1  asynchronous, active-high reset.
link_en  in  1  level; 1 = link enabled.
in_valid  in  1  upstream byte valid.
in_ready  out  1  upstream byte accepted when in_valid & in_ready at clk edge.
in_data  in  8  upstream byte.
in_sop  in  1  byte is first of packet (qualified by in_valid).
in_eop  in  1  byte is last of packet (may coincide with in_sop).
enc_dat  out  8  symbol to encoder ein_dat.
enc_k  out  1  to encoder kin_ena; 1 = control symbol.
enc_ena  out  1  to encoder ein_ena; 1 = data symbol.
enc_rd  out  1  to encoder ein_rd; registered running disparity (0 = RD-).
enc_rdcomb  in  1  from encoder eout_rdcomb.
trained  out  1  1 once TRAIN completes; cleared in OFF.
cc_active  out  1  1 while a skip burst is being emitted.
abort_pulse  out  1  one-cycle pulse when a packet is aborted.

Behaviour:
- Reset: all outputs 0, rd_reg=0, state OFF, slot parity=even, CC counter=CC_INTERVAL.
- All enc_* outputs are registered. An issue cycle has exactly one of enc_k/enc_ena high. Both low only in OFF.
- Disparity: on every issue cycle, rd_reg <= enc_rdcomb. enc_rd = rd_reg. Not updated when neither is high.
- Slot parity toggles each issue cycle. K28.5 (0xBC) is only issued in an even slot. Idle, skip and SOF always start in an even slot.
- Symbols: IDLE = K28.5 then D16.2 (0x50, enc_ena). SKIP = K28.5 then K28.0 (0x1C). SOF = K27.7 (0xFB). EOF = K29.7 (0xFD). PAD/underflow = K23.7 (0xF7). ABORT = K30.7 (0xFE).
- CC counter decrements every issue cycle and saturates at 0; cc_pending = (count==0). It is reloaded when a skip burst starts.
- OFF: no issue. When link_en=1, go to TRAIN next cycle and start at an even slot.
- TRAIN: emit TRAIN_PAIRS idle pairs, then set trained=1 and go to IDLE. CC is suppressed during TRAIN.
- IDLE, at each even slot, in priority order:
  - If cc_pending: go to CC.
  - Else if in_valid & in_sop: go to SOF.
  - Else: emit an idle pair.
  - A non-SOP in_valid in IDLE is dropped: in_ready=1 and the byte is discarded.
- SOF: issue 0xFB with in_ready=0, then DATA.
- DATA:
  - in_ready=1. Each accepted byte appears on enc_dat with enc_ena=1 in the next cycle (latency 1).
  - If in_valid=0, issue K23.7 and hold the state (underflow fill).
  - After the byte with in_eop is accepted, issue EOF next.
  - An in_sop inside DATA is treated as an ordinary byte.
- EOF: issue 0xFD. If the next slot is odd, issue one K23.7 pad. Then return to IDLE; a deferred cc_pending is served there.
- CC: cc_active=1; emit CC_PAIRS skip pairs, reload the counter, return to IDLE. in_ready=0 throughout.
- in_ready=0 in OFF, TRAIN, SOF, EOF, PAD, CC and ABORT.
- link_en falling:
  - In DATA/SOF: issue ABORT (0xFE) for one cycle, pulse abort_pulse, then go to OFF. The upstream remainder of the packet is not consumed.
  - In other states: go to OFF at the next even slot. A pending idle or skip pair always completes.
- OFF clears trained and the CC counter reload. rd_reg is retained.
- link_en re-asserted in the same cycle as entering OFF: honored on the next cycle, with retraining required.
- Async rst mid-operation immediately forces the reset values. No partial pair is completed.

Test Plan:
1. Reset, link_en=1, no in_valid → 128 symbols BC,50 alternating with enc_k/enc_ena alternating; trained rises after the 128th symbol; idles continue.
2. After training, 3-byte packet 11,22,33 (sop on 11, eop on 33) at an even slot → FB,11,22,33,FD,F7 then BC,50; in_ready high for exactly 3 accept cycles.
3. Packet with in_valid gap of 2 cycles after byte 1 → F7,F7 inserted between data bytes; no byte lost or duplicated.
4. CC_INTERVAL=16, continuous 40-byte packet → skip deferred until after FD(/F7); then BC,1C,BC,1C with cc_active=1 and in_ready=0; counter reloaded.
5. Disparity: drive enc_rdcomb = model output of the real encoder → enc_rd matches the reference RD sequence for every symbol; verify no update in OFF.
6. Drop link_en mid-packet → one FE with abort_pulse=1, then enc_k=enc_ena=0, trained=0; re-enable → fresh 64-pair training.
